// File: rtl/svx32_pkg.sv
// Shared types and default parameters for the svx32 data-memory slave.
package svx32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int unsigned DEF_DEPTH_WORDS = 32'd1024;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_2000;
  localparam int unsigned DEF_RD_LATENCY  = 32'd2;

  // Word-aligned range test done in 33 bits so BASE + 4*DEPTH cannot wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr[31:2], 2'b00};
    lo = {1'b0, base};
    hi = lo + {depth[30:0], 2'b00};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/svx32_dmem_slave_if.sv
// Core-to-data-memory request/response bundle.
interface svx32_dmem_slave_if;
  logic        pil_mem_req;
  logic        pil_mem_wen;
  logic [31:0] piv_mem_addr;
  logic [31:0] piv_mem_wdata;
  logic [3:0]  piv_mem_byte_sel;
  logic        pol_mem_ack;
  logic        pol_mem_valid;
  logic [31:0] pov_mem_rdata;
  logic        pol_mem_err;

  modport master (
    output pil_mem_req, pil_mem_wen, piv_mem_addr, piv_mem_wdata, piv_mem_byte_sel,
    input  pol_mem_ack, pol_mem_valid, pov_mem_rdata, pol_mem_err
  );

  modport slave (
    input  pil_mem_req, pil_mem_wen, piv_mem_addr, piv_mem_wdata, piv_mem_byte_sel,
    output pol_mem_ack, pol_mem_valid, pov_mem_rdata, pol_mem_err
  );
endinterface

// File: rtl/svx32_dmem_ram.sv
// Word store with per-byte write enables, one write port and one registered read port.
module svx32_dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 32'd1024,
  localparam int unsigned AW = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/svx32_dmem_slave.sv
// Data-memory slave: request FSM, address decode and read-latency counter
// in front of a byte-enabled word store.
module svx32_dmem_slave
  import svx32_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY
) (
  input  logic               pil_clk,
  input  logic               pil_rst,
  svx32_dmem_slave_if.slave  bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1;
  localparam logic [1:0] WAIT_LOAD = (RD_LATENCY >= 32'd2) ? 2'(RD_LATENCY - 32'd2) : 2'd0;

  state_t        r_state;
  logic          r_wen;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_bsel;
  logic          r_in_range;
  logic [1:0]    r_cnt;
  logic          r_ack;
  logic          r_valid;
  logic          r_err;
  logic [31:0]   r_rdata;

  logic          w_in_range;
  logic [AW-1:0] w_rd_index;
  logic [AW-1:0] w_wr_index;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [31:0]   w_ram_rdata;

  assign w_in_range = addr_in_range(bus.piv_mem_addr, BASE_ADDR, DEPTH_WORDS);
  assign w_rd_index = AW'((bus.piv_mem_addr - BASE_ADDR) >> 2);
  assign w_wr_index = AW'((r_addr - BASE_ADDR) >> 2);

  // The read is issued on the accepting edge; no write can land between then and ACK.
  assign w_ram_re = (r_state == ST_IDLE) && bus.pil_mem_req && !bus.pil_mem_wen;
  assign w_ram_we = (r_state == ST_ACK) && r_wen && r_in_range;

  svx32_dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .i_clk   (pil_clk),
    .i_we    (w_ram_we),
    .i_be    (r_bsel),
    .i_waddr (w_wr_index),
    .i_wdata (r_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_rd_index),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge pil_clk or posedge pil_rst) begin
    if (pil_rst) begin
      r_state    <= ST_IDLE;
      r_wen      <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_bsel     <= 4'h0;
      r_in_range <= 1'b0;
      r_cnt      <= 2'd0;
      r_ack      <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= 32'h0;
      case (r_state)
        ST_IDLE: begin
          if (bus.pil_mem_req) begin
            r_wen      <= bus.pil_mem_wen;
            r_addr     <= {bus.piv_mem_addr[31:2], 2'b00};
            r_wdata    <= bus.piv_mem_wdata;
            r_bsel     <= bus.piv_mem_byte_sel;
            r_in_range <= w_in_range;
            r_ack      <= 1'b1;
            r_err      <= !w_in_range;
            r_state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (r_wen) begin
            r_state <= ST_IDLE;
          end else if (RD_LATENCY <= 32'd1) begin
            r_valid <= 1'b1;
            r_rdata <= r_in_range ? w_ram_rdata : 32'h0;
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= WAIT_LOAD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_valid <= 1'b1;
            r_rdata <= r_in_range ? w_ram_rdata : 32'h0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pol_mem_ack   = r_ack;
  assign bus.pol_mem_valid = r_valid;
  assign bus.pol_mem_err   = r_err;
  assign bus.pov_mem_rdata = r_rdata;

endmodule

// File: tb/tb_svx32_dmem_slave.sv
// Directed bench for svx32_dmem_slave: main instance at RD_LATENCY=2 plus
// RD_LATENCY=1 and 4 instances for the latency sweep.
module tb_svx32_dmem_slave;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  svx32_dmem_slave_if if0 ();
  svx32_dmem_slave_if if1 ();
  svx32_dmem_slave_if if4 ();

  svx32_dmem_slave #(.RD_LATENCY(2)) dut0 (.pil_clk(clk), .pil_rst(rst), .bus(if0));
  svx32_dmem_slave #(.RD_LATENCY(1)) dut1 (.pil_clk(clk), .pil_rst(rst), .bus(if1));
  svx32_dmem_slave #(.RD_LATENCY(4)) dut4 (.pil_clk(clk), .pil_rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request on if0 from a negedge, then watch 14 cycles.
  // k counts rising edges after the request was first presented.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] bsel, input int hold,
                         output int ack1, output int ack2, output int val1,
                         output int nack, output int nval, output logic err_at_ack,
                         output logic [31:0] rdata, output int rd_bad);
    ack1 = -1; ack2 = -1; val1 = -1; nack = 0; nval = 0;
    err_at_ack = 1'b0; rdata = 32'h0; rd_bad = 0;
    @(negedge clk);
    if0.pil_mem_req      = 1'b1;
    if0.pil_mem_wen      = wen;
    if0.piv_mem_addr     = addr;
    if0.piv_mem_wdata    = wdata;
    if0.piv_mem_byte_sel = bsel;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (if0.pol_mem_ack) begin
        nack++;
        if (ack1 < 0) begin
          ack1 = k;
          err_at_ack = if0.pol_mem_err;
        end else if (ack2 < 0) begin
          ack2 = k;
        end
      end
      if (if0.pol_mem_valid) begin
        nval++;
        if (val1 < 0) begin
          val1 = k;
          rdata = if0.pov_mem_rdata;
        end
      end else if (if0.pov_mem_rdata !== 32'h0) begin
        rd_bad++;
      end
      if ((hold == 0 && nack > 0) || (hold > 0 && k >= hold)) begin
        if0.pil_mem_req = 1'b0;
      end
    end
    if0.pil_mem_req = 1'b0;
    if0.pil_mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (if0.pol_mem_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", if0.pol_mem_ack); end
    n_tests++;
    if (if0.pol_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if0.pol_mem_valid); end
    n_tests++;
    if (if0.pol_mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", if0.pol_mem_err); end
    n_tests++;
    if (if0.pov_mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", if0.pov_mem_rdata); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int a1, a2, v1, na, nv, bad;
    logic e;
    logic [31:0] d;
    run_txn(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (a1 !== 1) begin n_fail++; $display("FAIL wr_ack_time: got %0d want 1", a1); end
    n_tests++;
    if (nv !== 0) begin n_fail++; $display("FAIL wr_no_valid: got %0d valids want 0", nv); end
    n_tests++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", e); end
    run_txn(1'b0, 32'h0000_2004, 32'h0, 4'h0, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (a1 !== 1) begin n_fail++; $display("FAIL rd_ack_time: got %0d want 1", a1); end
    n_tests++;
    if (v1 !== 3) begin n_fail++; $display("FAIL rd_valid_time: got %0d want 3", v1); end
    n_tests++;
    if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", d); end
    n_tests++;
    if (na !== 1 || nv !== 1) begin n_fail++; $display("FAIL rd_pulse_count: got ack=%0d valid=%0d want 1/1", na, nv); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL rdata_idle_zero: got %0d nonzero cycles want 0", bad); end
  endtask

  task automatic test_partial_write();
    int a1, a2, v1, na, nv, bad;
    logic e;
    logic [31:0] d;
    run_txn(1'b1, 32'h0000_2008, 32'h1122_3344, 4'hF, 0, a1, a2, v1, na, nv, e, d, bad);
    run_txn(1'b1, 32'h0000_2008, 32'hAABB_CCDD, 4'b0101, 0, a1, a2, v1, na, nv, e, d, bad);
    run_txn(1'b0, 32'h0000_2008, 32'h0, 4'h0, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL partial_write: got %h want 11bb33dd", d); end
    run_txn(1'b1, 32'h0000_2008, 32'hFFFF_FFFF, 4'b0000, 0, a1, a2, v1, na, nv, e, d, bad);
    run_txn(1'b0, 32'h0000_2008, 32'h0, 4'h0, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL zero_byte_sel: got %h want 11bb33dd", d); end
  endtask

  task automatic test_out_of_range();
    int a1, a2, v1, na, nv, bad;
    logic e;
    logic [31:0] d;
    run_txn(1'b1, 32'h0000_2000, 32'h0102_0304, 4'hF, 0, a1, a2, v1, na, nv, e, d, bad);
    run_txn(1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b want 1", e); end
    n_tests++;
    if (v1 !== 3 || d !== 32'h0) begin n_fail++; $display("FAIL oor_rd_resp: got t=%0d data=%h want 3/0", v1, d); end
    run_txn(1'b1, 32'h0000_3000, 32'h5555_5555, 4'hF, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (e !== 1'b1 || a1 !== 1 || nv !== 0) begin n_fail++; $display("FAIL oor_wr: got err=%b ack=%0d valids=%0d want 1/1/0", e, a1, nv); end
    run_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (d !== 32'h0102_0304 || e !== 1'b0) begin n_fail++; $display("FAIL oor_wr_dropped: got %h err=%b want 01020304/0", d, e); end
    run_txn(1'b1, 32'h0000_2FFC, 32'h0BAD_F00D, 4'hF, 0, a1, a2, v1, na, nv, e, d, bad);
    run_txn(1'b0, 32'h0000_2FFC, 32'h0, 4'h0, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (d !== 32'h0BAD_F00D || e !== 1'b0) begin n_fail++; $display("FAIL last_word: got %h err=%b want 0badf00d/0", d, e); end
  endtask

  task automatic test_held_req();
    int a1, a2, v1, na, nv, bad;
    logic e;
    logic [31:0] d;
    run_txn(1'b0, 32'h0000_2008, 32'h0, 4'h0, 10, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (a1 !== 1 || v1 !== 3) begin n_fail++; $display("FAIL held_first: got ack=%0d valid=%0d want 1/3", a1, v1); end
    n_tests++;
    if (a2 !== 5) begin n_fail++; $display("FAIL held_second_ack: got %0d want 5", a2); end
    n_tests++;
    if (na !== 3 || nv !== 3) begin n_fail++; $display("FAIL held_counts: got ack=%0d valid=%0d want 3/3", na, nv); end
    n_tests++;
    if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL held_data: got %h want 11bb33dd", d); end
  endtask

  task automatic test_reset_in_wait();
    int a1, a2, v1, na, nv, bad;
    logic e;
    logic [31:0] d;
    int late_ack;
    int late_val;
    @(negedge clk);
    if0.pil_mem_req  = 1'b1;
    if0.pil_mem_wen  = 1'b0;
    if0.piv_mem_addr = 32'h0000_2004;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (if0.pol_mem_ack !== 1'b1) begin n_fail++; $display("FAIL rstwait_ack: got %b want 1", if0.pol_mem_ack); end
    if0.pil_mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({if0.pol_mem_ack, if0.pol_mem_valid, if0.pol_mem_err, if0.pov_mem_rdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL rstwait_outputs: got ack=%b valid=%b err=%b rdata=%h want all 0",
               if0.pol_mem_ack, if0.pol_mem_valid, if0.pol_mem_err, if0.pov_mem_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    late_ack = 0;
    late_val = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (if0.pol_mem_ack) late_ack++;
      if (if0.pol_mem_valid) late_val++;
    end
    n_tests++;
    if (late_ack !== 0 || late_val !== 0) begin n_fail++; $display("FAIL rstwait_aborted: got ack=%0d valid=%0d want 0/0", late_ack, late_val); end
    run_txn(1'b0, 32'h0000_2004, 32'h0, 4'h0, 0, a1, a2, v1, na, nv, e, d, bad);
    n_tests++;
    if (v1 !== 3 || d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rstwait_recover: got t=%0d data=%h want 3/deadbeef", v1, d); end
  endtask

  task automatic test_latency_sweep();
    int v1k, v4k;
    logic [31:0] d1, d4;
    v1k = -1; v4k = -1; d1 = 32'h0; d4 = 32'h0;
    @(negedge clk);
    if1.pil_mem_req = 1'b1; if1.pil_mem_wen = 1'b1; if1.piv_mem_addr = 32'h0000_2000;
    if1.piv_mem_wdata = 32'hCAFE_F00D; if1.piv_mem_byte_sel = 4'hF;
    if4.pil_mem_req = 1'b1; if4.pil_mem_wen = 1'b1; if4.piv_mem_addr = 32'h0000_2000;
    if4.piv_mem_wdata = 32'hCAFE_F00D; if4.piv_mem_byte_sel = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (if1.pol_mem_ack) if1.pil_mem_req = 1'b0;
      if (if4.pol_mem_ack) if4.pil_mem_req = 1'b0;
    end
    if1.pil_mem_req = 1'b1; if1.pil_mem_wen = 1'b0;
    if4.pil_mem_req = 1'b1; if4.pil_mem_wen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (if1.pol_mem_ack) if1.pil_mem_req = 1'b0;
      if (if4.pol_mem_ack) if4.pil_mem_req = 1'b0;
      if (if1.pol_mem_valid && v1k < 0) begin v1k = k; d1 = if1.pov_mem_rdata; end
      if (if4.pol_mem_valid && v4k < 0) begin v4k = k; d4 = if4.pov_mem_rdata; end
    end
    if1.pil_mem_req = 1'b0;
    if4.pil_mem_req = 1'b0;
    n_tests++;
    if (v1k !== 2) begin n_fail++; $display("FAIL lat1_time: got %0d want 2", v1k); end
    n_tests++;
    if (v4k !== 5) begin n_fail++; $display("FAIL lat4_time: got %0d want 5", v4k); end
    n_tests++;
    if (d1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat1_data: got %h want cafef00d", d1); end
    n_tests++;
    if (d4 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat4_data: got %h want cafef00d", d4); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    if0.pil_mem_req = 1'b0; if0.pil_mem_wen = 1'b0; if0.piv_mem_addr = 32'h0;
    if0.piv_mem_wdata = 32'h0; if0.piv_mem_byte_sel = 4'h0;
    if1.pil_mem_req = 1'b0; if1.pil_mem_wen = 1'b0; if1.piv_mem_addr = 32'h0;
    if1.piv_mem_wdata = 32'h0; if1.piv_mem_byte_sel = 4'h0;
    if4.pil_mem_req = 1'b0; if4.pil_mem_wen = 1'b0; if4.piv_mem_addr = 32'h0;
    if4.piv_mem_wdata = 32'h0; if4.piv_mem_byte_sel = 4'h0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_held_req();
    test_reset_in_wait();
    test_latency_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/svx32_dmem_slave.md
SVX32_DMEM_SLAVE -- requirements
Module: svx32_dmem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing store.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_2000, byte address of word 0.
REQ-003 SHALL have parameter RD_LATENCY, default 2, legal 1..4, cycles from ack to read-data valid.
REQ-004 pil_clk  input  1  sole clock; all state on rising edge.
REQ-005 pil_rst  input  1  reset, asynchronous, active-high.
REQ-006 pil_mem_req  input  1  core request; held high until pol_mem_ack seen.
REQ-007 pil_mem_wen  input  1  1 = write, 0 = read; qualified by pil_mem_req.
REQ-008 piv_mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 piv_mem_wdata  input  32  write data.
REQ-010 piv_mem_byte_sel  input  4  byte enables, bit n -> wdata[8n+7:8n].
REQ-011 pol_mem_ack  output  1  one-cycle request-accepted pulse.
REQ-012 pol_mem_valid  output  1  one-cycle read-data-valid pulse.
REQ-013 pov_mem_rdata  output  32  read data; meaningful only while pol_mem_valid=1.
REQ-014 pol_mem_err  output  1  one-cycle pulse, coincident with ack, for an out-of-range access.

Function
REQ-015 SHALL implement states IDLE, ACK, WAIT, RESP.
REQ-016 IDLE: when pil_mem_req=1, SHALL capture wen/addr/wdata/byte_sel and go to ACK; otherwise SHALL stay in IDLE.
REQ-017 ACK: SHALL drive pol_mem_ack=1 for exactly this cycle; SHALL go to IDLE for a write and to WAIT for a read.
REQ-018 Writes SHALL update the store at the ACK-state clock edge, only the bytes whose byte_sel bit is 1; byte_sel=4'b0000 SHALL leave the store unchanged.
REQ-019 Writes SHALL produce no pol_mem_valid pulse.
REQ-020 WAIT: SHALL count RD_LATENCY-1 cycles, then go to RESP; RD_LATENCY=1 SHALL pass through WAIT in zero cycles (ACK -> RESP directly).
REQ-021 RESP: SHALL drive pol_mem_valid=1 with pov_mem_rdata for one cycle, then go to IDLE.
REQ-022 Read timing: request first seen at cycle t -> ack at t+1 -> valid at t+1+RD_LATENCY.
REQ-023 pil_mem_req SHALL be sampled only in IDLE; req held high during ACK, WAIT or RESP SHALL NOT start a new transaction.
REQ-024 Back-to-back: req high in the first IDLE cycle after a completed transaction SHALL be accepted as a new transaction.
REQ-025 In range SHALL mean BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS; word index = (addr - BASE_ADDR) >> 2.
REQ-026 Out-of-range access: SHALL still ack and pulse pol_mem_err with that ack; a write SHALL be dropped; a read SHALL complete normally with rdata=32'h0.
REQ-027 pov_mem_rdata SHALL be 32'h0 whenever pol_mem_valid=0.
REQ-028 A read SHALL return the store contents as of its ACK cycle, including any write accepted in an earlier transaction.

Reset
REQ-029 pil_rst=1 SHALL immediately force state=IDLE, pol_mem_ack=0, pol_mem_valid=0, pol_mem_err=0, pov_mem_rdata=0 and clear the latency counter.
REQ-030 Reset mid-transaction SHALL abort the transaction with no ack or valid afterward; a write not yet committed SHALL be lost.
REQ-031 Store contents SHALL NOT be reset.

Structure
REQ-032 State enum and defaults for DEPTH_WORDS, BASE_ADDR and RD_LATENCY SHALL live in the shared package svx32_pkg.
REQ-033 The byte-enabled storage array SHALL be the sub-module svx32_dmem_ram (1 write port, 1 read port, per-byte write enable).
REQ-034 Control FSM, address decode and latency counter SHALL reside in svx32_dmem_slave.

Verification
REQ-035 Write then read: write addr=0x2004, wdata=0xDEADBEEF, byte_sel=4'hF, then read 0x2004 -> ack 1 cycle after each req; valid with rdata=0xDEADBEEF exactly 3 cycles after the read req (RD_LATENCY=2).
REQ-036 Partial write: store 0x11223344 at 0x2008, then write 0xAABBCCDD with byte_sel=4'b0101, then read 0x2008 -> rdata=0x11BB33DD.
REQ-037 Out of range: read 0x1FFC, and write 0x3000 with DEPTH_WORDS=1024 -> err pulses with each ack; read valid with rdata=0; store unchanged.
REQ-038 Held req: keep req=1 continuously for 10 cycles on a read -> exactly one ack and one valid before return to IDLE, then a second ack at the first IDLE cycle.
REQ-039 Reset in WAIT: assert pil_rst during WAIT of a read -> no valid pulse; all outputs 0; next request serviced normally.
REQ-040 Latency sweep: RD_LATENCY=1 and 4 -> valid at t+2 and t+5 respectively.
